// File: rtl/karatsuba_pp_seq_36bit_pkg.sv
// Shared constants, FSM state type and a reference carry-less multiply
// for the sequential 36-bit Karatsuba partial-product generator.
package kpm_pkg;

  localparam int N  = 36;           // operand width (even)
  localparam int HW = N / 2;        // half width / sub-multiplier width
  localparam int PW = N - 1;        // partial-product width
  localparam int CW = $clog2(HW);   // bit-counter width

  typedef enum logic [2:0] {
    IDLE,
    MUL_L,
    MUL_H,
    MUL_M,
    DONE
  } kpm_state_t;

  // Carry-less HW x HW product; used by the bench as a golden model.
  function automatic logic [PW-1:0] clmul_ref(input logic [HW-1:0] a,
                                              input logic [HW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < HW; i++) begin
      if (b[i]) r = r ^ (PW'(a) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2_serial_mul_18bit.sv
// Bit-serial 18x18 carry-less multiplier datapath: one multiplier bit per
// step, MSB first, acc = (acc << 1) ^ (bit ? a : 0).
module gf2_serial_mul_18bit
  import kpm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  input  logic          step,
  output logic [PW-1:0] acc
);

  logic [HW-1:0] a_q;
  logic [HW-1:0] b_q;
  // Before the final step the partial sum has degree <= PW-2, so the stored
  // accumulator needs one bit less than the full product; the full-width
  // value only exists on acc during the last step, where the top captures it.
  logic [PW-2:0] acc_q;

  // Result of applying the current step; the top samples it on the last cycle.
  always_comb begin
    acc = {acc_q, 1'b0} ^ (b_q[HW-1] ? PW'(a_q) : '0);
  end

  // Operand load has priority over stepping so a new phase can start on the
  // same edge the previous one finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
    end else if (step) begin
      acc_q <= acc[PW-2:0];
      b_q   <= {b_q[HW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/karatsuba_pp_seq_36bit.sv
// Sequential Karatsuba partial-product generator: computes L = Al*Bl,
// H = Ah*Bh and M = (Al^Ah)*(Bl^Bh) ^ L ^ H over GF(2) by time-sharing one
// bit-serial 18x18 multiplier, then offers them with valid/ready.
module karatsuba_pp_seq_36bit
  import kpm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] pp_lo,
  output logic [PW-1:0] pp_mid,
  output logic [PW-1:0] pp_hi
);

  kpm_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [PW-1:0] pp_lo_q, pp_lo_d;
  logic [PW-1:0] pp_mid_q, pp_mid_d;
  logic [PW-1:0] pp_hi_q, pp_hi_d;
  logic          out_valid_q, out_valid_d;

  logic          mul_load;
  logic          mul_step;
  logic [HW-1:0] mul_a;
  logic [HW-1:0] mul_b;
  logic [PW-1:0] mul_acc;
  logic          last_bit;

  gf2_serial_mul_18bit u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mul_load),
    .a     (mul_a),
    .b     (mul_b),
    .step  (mul_step),
    .acc   (mul_acc)
  );

  assign last_bit  = (cnt_q == CW'(HW - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign pp_lo     = pp_lo_q;
  assign pp_mid    = pp_mid_q;
  assign pp_hi     = pp_hi_q;

  // Next-state, phase sequencing and sub-multiplier control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    pp_lo_d     = pp_lo_q;
    pp_mid_d    = pp_mid_q;
    pp_hi_d     = pp_hi_q;
    out_valid_d = out_valid_q;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    mul_a       = '0;
    mul_b       = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a_in;
          b_d      = b_in;
          mul_load = 1'b1;
          mul_a    = a_in[HW-1:0];
          mul_b    = b_in[HW-1:0];
          cnt_d    = '0;
          state_d  = MUL_L;
        end
      end
      MUL_L: begin
        mul_step = 1'b1;
        if (last_bit) begin
          pp_lo_d  = mul_acc;
          mul_load = 1'b1;
          mul_a    = a_q[N-1:HW];
          mul_b    = b_q[N-1:HW];
          cnt_d    = '0;
          state_d  = MUL_H;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MUL_H: begin
        mul_step = 1'b1;
        if (last_bit) begin
          pp_hi_d  = mul_acc;
          mul_load = 1'b1;
          mul_a    = a_q[HW-1:0] ^ a_q[N-1:HW];
          mul_b    = b_q[HW-1:0] ^ b_q[N-1:HW];
          cnt_d    = '0;
          state_d  = MUL_M;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MUL_M: begin
        mul_step = 1'b1;
        if (last_bit) begin
          pp_mid_d    = mul_acc ^ pp_lo_q ^ pp_hi_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pp_lo_q     <= '0;
      pp_mid_q    <= '0;
      pp_hi_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pp_lo_q     <= pp_lo_d;
      pp_mid_q    <= pp_mid_d;
      pp_hi_q     <= pp_hi_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_karatsuba_pp_seq_36bit.sv
// Directed bench for the sequential Karatsuba partial-product generator.
module tb_karatsuba_pp_seq_36bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] a_in;
  logic [35:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [34:0] pp_lo;
  logic [34:0] pp_mid;
  logic [34:0] pp_hi;

  int checks;
  int failures;
  int cyc;
  int prev_accept;

  karatsuba_pp_seq_36bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_lo     (pp_lo),
    .pp_mid    (pp_mid),
    .pp_hi     (pp_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [71:0] got,
                           input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent full-width carry-less product.
  function automatic logic [71:0] clmul36(input logic [35:0] a,
                                          input logic [35:0] b);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 36; i++) begin
      if (b[i]) r = r ^ (72'(a) << i);
    end
    return r;
  endfunction

  // One full transaction: accept, latency, results, optional stall, handshake.
  task automatic do_txn(input string tag, input logic [35:0] a,
                        input logic [35:0] b, input logic [34:0] el,
                        input logic [34:0] em, input logic [34:0] eh,
                        input bit early_ready, input int stall,
                        input bit chk_interval);
    int n;
    int acc_cyc;
    bit stable;
    logic [34:0] sl, sm, sh;
    logic [71:0] full;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_in_ready"}, 72'(in_ready), 72'(1));
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = early_ready;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; a_in = ~a; b_in = ~b;
    if (chk_interval) check_val({tag, "_interval"}, 72'(acc_cyc - prev_accept), 72'(56));
    prev_accept = acc_cyc;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_latency"}, 72'(n), 72'(54));
    check_val({tag, "_lo"}, 72'(pp_lo), 72'(el));
    check_val({tag, "_mid"}, 72'(pp_mid), 72'(em));
    check_val({tag, "_hi"}, 72'(pp_hi), 72'(eh));
    full = 72'(pp_lo) ^ (72'(pp_mid) << 18) ^ (72'(pp_hi) << 36);
    check_val({tag, "_product"}, full, clmul36(a, b));
    sl = pp_lo; sm = pp_mid; sh = pp_hi;
    if (!early_ready) begin
      stable = 1'b1;
      in_valid = 1'b1; a_in = 36'h5_5555_5555; b_in = 36'hA_AAAA_AAAA;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || pp_lo !== sl || pp_mid !== sm || pp_hi !== sh)
          stable = 1'b0;
      end
      in_valid = 1'b0;
      if (stall > 0) check_val({tag, "_stall_stable"}, 72'(stable), 72'(1));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_valid_drop"}, 72'(out_valid), 72'(0));
    check_val({tag, "_ready_back"}, 72'(in_ready), 72'(1));
    check_val({tag, "_lo_held"}, 72'(pp_lo), 72'(sl));
    $display("txn %s a=%h b=%h lo=%h mid=%h hi=%h lat=%0d", tag, a, b, pp_lo, pp_mid, pp_hi, n);
  endtask

  task automatic rand_txn(input string tag, input bit chk_interval);
    logic [63:0] ra, rb;
    logic [35:0] a, b;
    logic [34:0] l, h, m;
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    a = ra[35:0];
    b = rb[35:0];
    l = kpm_pkg::clmul_ref(a[17:0], b[17:0]);
    h = kpm_pkg::clmul_ref(a[35:18], b[35:18]);
    m = kpm_pkg::clmul_ref(a[17:0] ^ a[35:18], b[17:0] ^ b[35:18]) ^ l ^ h;
    do_txn(tag, a, b, l, m, h, 1'b1, 0, chk_interval);
  endtask

  initial begin
    bit pulsed;
    logic [35:0] ra, rb;
    logic [34:0] l, h, m;
    checks = 0; failures = 0; cyc = 0; prev_accept = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 72'(out_valid), 72'(0));
    check_val("rst_in_ready", 72'(in_ready), 72'(1));
    check_val("rst_pp", {pp_hi[0], pp_mid, pp_lo}, 72'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn("one_one", 36'h1, 36'h1, 35'h1, 35'h0, 35'h0, 1'b0, 0, 1'b0);
    do_txn("ah_bl", 36'h4_0000, 36'h1, 35'h0, 35'h1, 35'h0, 1'b0, 0, 1'b0);
    do_txn("ah_bh", 36'h4_0000, 36'h4_0000, 35'h0, 35'h0, 35'h1, 1'b1, 0, 1'b0);
    do_txn("ones_x3", 36'hF_FFFF_FFFF, 36'h3, 35'h40001, 35'h40001, 35'h0, 1'b0, 10, 1'b0);

    // Back-to-back: each next pair offered as soon as the handshake completes.
    rand_txn("rand0", 1'b0);
    for (int i = 1; i < 4; i++) rand_txn($sformatf("rand%0d", i), 1'b1);

    // Reset in the middle of the H phase.
    ra = 36'h1_2345_6789; rb = 36'h0_ABCD_EF01;
    a_in = ra; b_in = rb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_in_ready", 72'(in_ready), 72'(1));
    check_val("midrst_out_valid", 72'(out_valid), 72'(0));
    check_val("midrst_pp", {pp_hi[0], pp_mid, pp_lo}, 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulsed = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) pulsed = 1'b1;
    end
    check_val("midrst_no_pulse", 72'(pulsed), 72'(0));
    $display("txn midrst a=%h b=%h discarded", ra, rb);
    l = kpm_pkg::clmul_ref(rb[17:0], ra[17:0]);
    h = kpm_pkg::clmul_ref(rb[35:18], ra[35:18]);
    m = kpm_pkg::clmul_ref(rb[17:0] ^ rb[35:18], ra[17:0] ^ ra[35:18]) ^ l ^ h;
    do_txn("after_rst", rb, ra, l, m, h, 1'b0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
